debounce_bank: RTL

Parametrised multi-channel switch debouncer for push-buttons and mechanical contacts feeding control logic. Per channel it synchronises the raw pin, filters bounce with a restartable stability counter, and outputs a filtered level plus one-cycle rise, fall and long-press pulses. Compared with the earlier single-channel debouncer it adds a reset, a metastability synchroniser, N channels, a configurable stability window and long-press detection.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_bank_if.sv | 15 +
 rtl/debounce_chan.sv | 105 ++++++++++
 rtl/debounce_bank.sv | 45 ++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the debounce bank.
package debounce_pkg;

  localparam int unsigned DEF_STABLE = 50000;
  localparam int unsigned DEF_SYNC   = 2;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Raw switch inputs and filtered outputs of an N-channel debounce bank.
interface debounce_bank_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] i;
  logic [N-1:0] st_o;
  logic [N-1:0] up_o;
  logic [N-1:0] dn_o;
  logic [N-1:0] long_o;

  // Producer of raw inputs / consumer of filtered results.
  modport master (output i, input st_o, up_o, dn_o, long_o);
  // The debouncer itself.
  modport slave  (input i, output st_o, up_o, dn_o, long_o);
endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, restartable stability counter,
// edge pulses and optional long-press detection.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE      = DEF_STABLE,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = DEF_SYNC,
  parameter int unsigned LONG_CYC    = 0,
  parameter logic        INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_i,
  output logic st_o,
  output logic up_o,
  output logic dn_o,
  output logic long_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   st_q, st_d;
  logic                   up_q, up_d;
  logic                   dn_q, dn_d;
  logic                   s;
  logic                   flip;

  always_comb begin
    s      = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], i_i};
    flip   = (s != st_q) && (cnt_q == LAST);
    st_d   = st_q;
    cnt_d  = '0;
    up_d   = 1'b0;
    dn_d   = 1'b0;
    // Any sample matching the current state leaves cnt_d at zero,
    // which is what restarts the window on a bounce.
    if (s != st_q) begin
      if (flip) begin
        st_d = s;
        up_d = s;
        dn_d = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT}};
      cnt_q  <= '0;
      st_q   <= INIT;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
    end
  end

  assign st_o = st_q;
  assign up_o = up_q;
  assign dn_o = dn_q;

  if (LONG_CYC > 0) begin : g_long
    localparam int unsigned HW = clog2(LONG_CYC + 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_q, long_d;

    // hcnt saturates at LONG_CYC, so the pulse fires once per press.
    always_comb begin
      hcnt_d = hcnt_q;
      long_d = 1'b0;
      if (flip || !st_q) begin
        hcnt_d = '0;
      end else if (hcnt_q < HW'(LONG_CYC)) begin
        hcnt_d = hcnt_q + HW'(1);
        long_d = (hcnt_q == HW'(LONG_CYC - 1));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt_q <= '0;
        long_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_d;
        long_q <= long_d;
      end
    end

    assign long_o = long_q;
  end else begin : g_no_long
    assign long_o = 1'b0;
  end

endmodule

// File: rtl/debounce_bank.sv
// N-channel switch debouncer: parameter checks and per-channel slicing.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned STABLE      = DEF_STABLE,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = DEF_SYNC,
  parameter int unsigned LONG_CYC    = 0,
  parameter logic        INIT        = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_bank_if.slave  bus
);

  if (STABLE < 1) begin : g_bad_stable
    $error("debounce_bank: STABLE must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_bank: SYNC_STAGES must be >= 2");
  end
  if (64'(STABLE) > (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("debounce_bank: STABLE exceeds 2**CNT_W");
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    debounce_chan #(
      .STABLE      (STABLE),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .LONG_CYC    (LONG_CYC),
      .INIT        (INIT)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_i    (bus.i[g]),
      .st_o   (bus.st_o[g]),
      .up_o   (bus.up_o[g]),
      .dn_o   (bus.dn_o[g]),
      .long_o (bus.long_o[g])
    );
  end

endmodule
